instr_mem_responder: RTL

- Responder end of the instruction fetch bus (req/gnt/valid protocol). Serves word reads from an internal instruction array.
- Sits opposite the fetch stage in the core testbench and in the FPGA top.
- Grants requests subject to an outstanding-transaction limit and external stall. Returns in-order responses a fixed LATENCY cycles after grant. Flags out-of-range addresses with instr_err.
- A side-band load port preloads the array.

---
 rtl/instr_mem_responder.sv | 118 +++++++++++
 1 files changed

// File: rtl/instr_mem_responder.sv
// Instruction-fetch responder: grants req/gnt/valid fetches and answers them in order from a preloadable word array.
// Define INSTR_MEM_RANDOM_STALL_EN to add LFSR-driven random grant stalls for protocol stress.
module instr_mem_responder #(
  parameter int          DEPTH_WORDS     = 1024,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int          LATENCY         = 1,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        instr_req,
  input  logic [31:0] instr_addr,
  output logic        instr_gnt,
  output logic [31:0] instr_rdata,
  output logic        instr_err,
  output logic        instr_valid,
  input  logic        stall_gnt,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic [2:0]  outstanding_cnt
);

  localparam int          AW          = $clog2(DEPTH_WORDS);
  localparam logic [32:0] DEPTH_BYTES = 33'(DEPTH_WORDS) << 2;

  logic [31:0]        mem [DEPTH_WORDS];
  logic [32:0]        fetch_off;
  logic [32:0]        load_off;
  logic               fetch_in_range;
  logic               load_in_range;
  logic [AW-1:0]      fetch_idx;
  logic [AW-1:0]      load_idx;
  logic               rand_stall;
  logic [LATENCY-1:0] stage_valid;
  logic [LATENCY-1:0] stage_err;
  logic [31:0]        stage_data [LATENCY];

  // 33-bit offsets: anything below BASE_ADDR wraps to a huge value and fails the range test
  always_comb begin
    fetch_off      = {1'b0, instr_addr} - {1'b0, BASE_ADDR};
    load_off       = {1'b0, load_addr} - {1'b0, BASE_ADDR};
    fetch_in_range = (fetch_off < DEPTH_BYTES);
    load_in_range  = (load_off < DEPTH_BYTES);
    fetch_idx      = fetch_off[AW+1:2];
    load_idx       = load_off[AW+1:2];
  end

`ifdef INSTR_MEM_RANDOM_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign rand_stall = (lfsr[1:0] == 2'b00);
`else
  assign rand_stall = 1'b0;
`endif

  // A response leaving this cycle frees its slot for a new grant
  always_comb begin
    instr_gnt = instr_req & ~stall_gnt & ~rand_stall &
                ((outstanding_cnt < 3'(MAX_OUTSTANDING)) | instr_valid);
  end

  always_ff @(posedge clk) begin
    if (load_en && load_in_range) begin
      mem[load_idx] <= load_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_valid <= '0;
      stage_err   <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        stage_data[i] <= '0;
      end
    end else begin
      stage_valid[0] <= instr_gnt;
      stage_err[0]   <= instr_gnt & ~fetch_in_range;
      stage_data[0]  <= (instr_gnt && fetch_in_range) ? mem[fetch_idx] : 32'h0;
      for (int i = 1; i < LATENCY; i++) begin
        stage_valid[i] <= stage_valid[i-1];
        stage_err[i]   <= stage_err[i-1];
        stage_data[i]  <= stage_data[i-1];
      end
    end
  end

  assign instr_valid = stage_valid[LATENCY-1];
  assign instr_err   = stage_err[LATENCY-1];
  assign instr_rdata = stage_data[LATENCY-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outstanding_cnt <= 3'd0;
    end else if (instr_gnt && !instr_valid) begin
      outstanding_cnt <= outstanding_cnt + 3'd1;
    end else if (!instr_gnt && instr_valid) begin
      outstanding_cnt <= outstanding_cnt - 3'd1;
    end
  end

`ifndef SYNTHESIS
  param_legal: assert property (@(posedge clk)
    (LATENCY >= 1) && (LATENCY <= 4) && (MAX_OUTSTANDING >= 1) && (MAX_OUTSTANDING <= 4));

  valid_needs_outstanding: assert property (@(posedge clk) disable iff (!reset_n)
    instr_valid |-> (outstanding_cnt != 3'd0));
`endif

endmodule
